// File: rtl/seq_compare.sv
// rtl/seq_compare.sv - multi-cycle sliced magnitude/equality comparator, MSB slice first
module seq_compare #(
    parameter int WIDTH      = 32,
    parameter int CHUNK      = 8,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_eq,
    output logic             out_lt,
    output logic             out_gt,
    output logic             busy
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    // A width that is not a whole number of slices cannot be scanned.
    if (WIDTH % CHUNK != 0) begin : g_cfg_err
        $error("seq_compare: WIDTH (%0d) must be a multiple of CHUNK (%0d)", WIDTH, CHUNK);
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CMP  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_signed;
    logic [IDXW-1:0]    r_idx;
    logic               r_found;
    logic               r_lt;
    logic               r_gt;
    logic               r_out_valid;
    logic               r_out_eq;
    logic               r_out_lt;
    logic               r_out_gt;

    logic [WIDTH-1:0]             w_a_bias;
    logic [WIDTH-1:0]             w_b_bias;
    logic [NSLICE-1:0][CHUNK-1:0] w_a_v;
    logic [NSLICE-1:0][CHUNK-1:0] w_b_v;
    logic [CHUNK-1:0]             w_a_s;
    logic [CHUNK-1:0]             w_b_s;
    logic                         w_diff;
    logic                         w_slt;
    logic                         w_first;
    logic                         w_found_now;
    logic                         w_lt_next;
    logic                         w_gt_next;
    logic                         w_last;
    logic                         w_stop;

    // Flipping the sign bit maps two's-complement order onto unsigned order.
    // Only the top slice holds that bit, so biasing the whole word is equivalent
    // to biasing the top slice alone.
    assign w_a_bias = r_a ^ {r_signed, {(WIDTH-1){1'b0}}};
    assign w_b_bias = r_b ^ {r_signed, {(WIDTH-1){1'b0}}};

    assign w_a_v = w_a_bias;
    assign w_b_v = w_b_bias;
    assign w_a_s = w_a_v[r_idx];
    assign w_b_s = w_b_v[r_idx];

    assign w_diff      = (w_a_s != w_b_s);
    assign w_slt       = (w_a_s < w_b_s);
    // Only the most significant differing slice decides the ordering.
    assign w_first     = w_diff & ~r_found;
    assign w_found_now = r_found | w_diff;
    assign w_lt_next   = w_first ? w_slt  : r_lt;
    assign w_gt_next   = w_first ? ~w_slt : r_gt;
    assign w_last      = (r_idx == IDXW'(0));
    assign w_stop      = w_last | (EARLY_EXIT & w_first);

    assign in_ready  = (r_state == S_IDLE) & ~reset;
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign out_eq    = r_out_eq;
    assign out_lt    = r_out_lt;
    assign out_gt    = r_out_gt;

    // Control FSM: accept in IDLE, scan one slice per cycle in CMP, hold result in DONE.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_signed    <= 1'b0;
            r_idx       <= '0;
            r_found     <= 1'b0;
            r_lt        <= 1'b0;
            r_gt        <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_eq    <= 1'b0;
            r_out_lt    <= 1'b0;
            r_out_gt    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a      <= in_a;
                        r_b      <= in_b;
                        r_signed <= in_signed;
                        r_idx    <= IDXW'(NSLICE - 1);
                        r_found  <= 1'b0;
                        r_lt     <= 1'b0;
                        r_gt     <= 1'b0;
                        r_state  <= S_CMP;
                    end
                end
                S_CMP: begin
                    if (w_first) begin
                        r_found <= 1'b1;
                        r_lt    <= w_slt;
                        r_gt    <= ~w_slt;
                    end
                    if (w_stop) begin
                        // Latched lt/gt stay zero when no slice differed.
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_out_eq    <= ~w_found_now;
                        r_out_lt    <= w_lt_next;
                        r_out_gt    <= w_gt_next;
                    end else begin
                        r_idx <= r_idx - IDXW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_compare.sv
// tb/tb_seq_compare.sv - scoreboard bench for seq_compare in three configurations
module tb_seq_compare;

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  iv;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        in_signed;
    logic        out_ready;
    wire  [2:0]  ir;
    wire  [2:0]  ov;
    wire  [2:0]  eq;
    wire  [2:0]  lt;
    wire  [2:0]  gt;
    wire  [2:0]  bz;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0] flags;
        int         k;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    // 0: 32/8 early exit, 1: 32/8 fixed latency, 2: 16/16 single cycle
    seq_compare #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1'b1)) u_ee (
        .clock(clock), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
        .out_valid(ov[0]), .out_ready(out_ready),
        .out_eq(eq[0]), .out_lt(lt[0]), .out_gt(gt[0]), .busy(bz[0])
    );

    seq_compare #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1'b0)) u_fl (
        .clock(clock), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
        .in_a(in_a), .in_b(in_b), .in_signed(in_signed),
        .out_valid(ov[1]), .out_ready(out_ready),
        .out_eq(eq[1]), .out_lt(lt[1]), .out_gt(gt[1]), .busy(bz[1])
    );

    seq_compare #(.WIDTH(16), .CHUNK(16), .EARLY_EXIT(1'b1)) u_16 (
        .clock(clock), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
        .in_a(in_a[15:0]), .in_b(in_b[15:0]), .in_signed(in_signed),
        .out_valid(ov[2]), .out_ready(out_ready),
        .out_eq(eq[2]), .out_lt(lt[2]), .out_gt(gt[2]), .busy(bz[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ef = {eq,lt,gt}; ek = cycles from acceptance edge to DONE entry
    task automatic do_cmp(input int sel, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [2:0] ef, input int ek, input int hold);
        exp_t       e;
        int         cyc;
        logic [2:0] f0;
        @(negedge clock);
        chk("in_ready_idle", 32'(ir[sel]), 32'd1);
        in_a      = a;
        in_b      = b;
        in_signed = s;
        iv[sel]   = 1'b1;
        out_ready = 1'b0;
        sb.push_back('{ef, ek});
        @(negedge clock);
        // scramble inputs: the captured operands must be unaffected
        iv[sel]   = 1'b0;
        in_a      = $urandom;
        in_b      = $urandom;
        in_signed = ~s;
        cyc = 0;
        while (ov[sel] !== 1'b1 && cyc < 64) begin
            @(negedge clock);
            cyc++;
        end
        e = sb.pop_front();
        chk("latency", 32'(cyc), 32'(e.k));
        chk("flags", 32'({eq[sel], lt[sel], gt[sel]}), 32'(e.flags));
        chk("onehot", 32'($countones({eq[sel], lt[sel], gt[sel]})), 32'd1);
        chk("busy_ready_done", 32'({bz[sel], ir[sel]}), 32'b10);
        f0 = {eq[sel], lt[sel], gt[sel]};
        for (int i = 0; i < hold; i++) begin
            @(negedge clock);
            chk("hold_stable", 32'({ov[sel], eq[sel], lt[sel], gt[sel], ir[sel], bz[sel]}),
                32'({1'b1, f0, 1'b0, 1'b1}));
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        chk("release_idle", 32'({ov[sel], bz[sel], ir[sel]}), 32'b001);
        chk("flags_held", 32'({eq[sel], lt[sel], gt[sel]}), 32'(f0));
    endtask

    initial begin
        logic [15:0] a16;
        logic [15:0] b16;
        logic        s;
        logic [2:0]  ef;

        reset     = 1'b1;
        iv        = 3'b000;
        in_a      = '0;
        in_b      = '0;
        in_signed = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_state", 32'({ir, ov, eq, lt, gt, bz}), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("ir_after_reset", 32'(ir), 32'b111);

        // equal operands scan every slice
        do_cmp(0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3'b100, 4, 0);
        // signedness flips the verdict; top slice differs so one cycle
        do_cmp(0, 32'h80000000, 32'h00000001, 1'b1, 3'b010, 1, 0);
        do_cmp(0, 32'h80000000, 32'h00000001, 1'b0, 3'b001, 1, 0);
        // difference only in the lowest slice
        do_cmp(0, 32'h12345678, 32'h12345679, 1'b0, 3'b010, 4, 0);
        // fixed latency: top-slice mismatch still takes all slices
        do_cmp(1, 32'h02000000, 32'h01000000, 1'b0, 3'b001, 4, 0);
        // later slice disagreeing must not override the first decision
        do_cmp(1, 32'h7F000000, 32'h000000FF, 1'b0, 3'b001, 4, 0);
        do_cmp(1, 32'h00000000, 32'h00000000, 1'b1, 3'b100, 4, 0);
        // slice 1 differs first: k = 4 - 1
        do_cmp(0, 32'h00001000, 32'h00002000, 1'b0, 3'b010, 3, 10);

        // reset in the second CMP cycle of an equal compare
        @(negedge clock);
        in_a      = 32'hCAFEF00D;
        in_b      = 32'hCAFEF00D;
        in_signed = 1'b0;
        iv[0]     = 1'b1;
        @(negedge clock);
        iv[0] = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("mid_reset_ready_low", 32'({bz[0], ir[0]}), 32'b10);
        @(negedge clock);
        chk("mid_reset_cleared", 32'({ov[0], eq[0], lt[0], gt[0], bz[0]}), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("post_reset_idle", 32'({ov[0], ir[0], bz[0]}), 32'b010);
        do_cmp(0, 32'hFFFFFFFF, 32'h00000000, 1'b1, 3'b010, 1, 0);

        // single-slice configuration against a reference model
        for (int i = 0; i < 1000; i++) begin
            a16 = 16'($urandom);
            b16 = ($urandom_range(0, 7) == 0) ? a16 : 16'($urandom);
            s   = 1'($urandom);
            if (a16 == b16)
                ef = 3'b100;
            else if (s ? ($signed(a16) < $signed(b16)) : (a16 < b16))
                ef = 3'b010;
            else
                ef = 3'b001;
            do_cmp(2, {16'h0, a16}, {16'h0, b16}, s, ef, 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
